// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master shifter.
package spi_pkg;

  // Default SPI word width, matching the upstream TX FIFO.
  localparam int SPI_WORD_W = 16;

  // Transaction sequencer states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    GAP   = 2'd3
  } spi_state_e;

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK generator: divides clk down to SCLK while enabled and flags the
// clk cycle just before each SCLK rising or falling toggle.
module spi_sclk_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic sclk,
  output logic rise_tick,
  output logic fall_tick
);

  localparam int                 DIV_W    = $clog2(CLK_DIV + 1);
  localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt_r;
  logic             sclk_r;
  logic             term_s;

  // Half-period terminal count and toggle direction decode.
  always_comb begin
    term_s    = 1'b0;
    rise_tick = 1'b0;
    fall_tick = 1'b0;
    if (enable && (div_cnt_r == DIV_LAST)) begin
      term_s    = 1'b1;
      rise_tick = ~sclk_r;
      fall_tick = sclk_r;
    end else begin
      term_s    = 1'b0;
    end
  end

  // Divider counter and SCLK register; both parked at zero while disabled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt_r <= {DIV_W{1'b0}};
      sclk_r    <= 1'b0;
    end else if (!enable) begin
      div_cnt_r <= {DIV_W{1'b0}};
      sclk_r    <= 1'b0;
    end else if (term_s) begin
      div_cnt_r <= {DIV_W{1'b0}};
      sclk_r    <= ~sclk_r;
    end else begin
      div_cnt_r <= div_cnt_r + DIV_W'(1);
    end
  end

  assign sclk = sclk_r;

endmodule

// File: rtl/spi_master_shifter.sv
// Mode-0 SPI master: pops words from a sync FIFO, shifts them out MSB-first
// on MOSI while capturing MISO, and reports each received word with a pulse.
module spi_master_shifter
  import spi_pkg::*;
#(
  parameter int WIDTH   = SPI_WORD_W,
  parameter int CLK_DIV = 2,
  parameter int CS_GAP  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             fifo_rempty,
  output logic             fifo_rinc,
  input  logic [WIDTH-1:0] fifo_rdata,
  output logic             sclk,
  output logic             cs_n,
  output logic             mosi,
  input  logic             miso,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             busy
);

  localparam int               BIT_W    = $clog2(WIDTH + 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH);
  localparam int               GAP_W    = $clog2(CS_GAP + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_GAP - 1);

  spi_state_e       state_r;
  spi_state_e       state_next_s;
  logic             fifo_rinc_s;
  logic [WIDTH-1:0] tx_sr_r;
  logic [WIDTH-1:0] rx_sr_r;
  logic [WIDTH-1:0] rx_data_r;
  logic [BIT_W-1:0] bit_cnt_r;
  logic [GAP_W-1:0] gap_cnt_r;
  logic             cs_n_r;
  logic             rx_valid_r;
  logic             busy_r;
  logic             shift_en_s;
  logic             rise_tick_s;
  logic             fall_tick_s;

  assign shift_en_s = (state_r == SHIFT);

  spi_sclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk_gen (
    .clk       (clk),
    .rst       (rst),
    .enable    (shift_en_s),
    .sclk      (sclk),
    .rise_tick (rise_tick_s),
    .fall_tick (fall_tick_s)
  );

  // Next-state decode and the FIFO pop strobe (gated by reset so a held
  // reset can never consume a word).
  always_comb begin
    state_next_s = state_r;
    fifo_rinc_s  = 1'b0;
    case (state_r)
      IDLE: begin
        fifo_rinc_s = en & ~fifo_rempty & rst;
        if (fifo_rinc_s) begin
          state_next_s = LOAD;
        end else begin
          state_next_s = IDLE;
        end
      end
      LOAD: begin
        state_next_s = SHIFT;
      end
      SHIFT: begin
        if (fall_tick_s && (bit_cnt_r == BIT_LAST)) begin
          state_next_s = GAP;
        end else begin
          state_next_s = SHIFT;
        end
      end
      GAP: begin
        if (gap_cnt_r == GAP_LAST) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = GAP;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // State register with a registered busy flag tracking the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      busy_r  <= (state_next_s != IDLE);
    end
  end

  // Shift registers, bit/gap counters, chip select and receive handshake.
  // MOSI is the MSB of tx_sr, so loading and left-shifting present each bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_sr_r    <= {WIDTH{1'b0}};
      rx_sr_r    <= {WIDTH{1'b0}};
      rx_data_r  <= {WIDTH{1'b0}};
      bit_cnt_r  <= {BIT_W{1'b0}};
      gap_cnt_r  <= {GAP_W{1'b0}};
      cs_n_r     <= 1'b1;
      rx_valid_r <= 1'b0;
    end else begin
      rx_valid_r <= 1'b0;
      case (state_r)
        LOAD: begin
          tx_sr_r   <= fifo_rdata;
          cs_n_r    <= 1'b0;
          bit_cnt_r <= {BIT_W{1'b0}};
        end
        SHIFT: begin
          if (rise_tick_s) begin
            rx_sr_r   <= {rx_sr_r[WIDTH-2:0], miso};
            bit_cnt_r <= bit_cnt_r + BIT_W'(1);
          end else if (fall_tick_s) begin
            if (bit_cnt_r == BIT_LAST) begin
              cs_n_r     <= 1'b1;
              rx_data_r  <= rx_sr_r;
              rx_valid_r <= 1'b1;
              gap_cnt_r  <= {GAP_W{1'b0}};
            end else begin
              tx_sr_r <= {tx_sr_r[WIDTH-2:0], 1'b0};
            end
          end else begin
            tx_sr_r <= tx_sr_r;
          end
        end
        GAP: begin
          gap_cnt_r <= gap_cnt_r + GAP_W'(1);
        end
        default: begin
          tx_sr_r <= tx_sr_r;
        end
      endcase
    end
  end

  assign fifo_rinc = fifo_rinc_s;
  assign cs_n      = cs_n_r;
  assign mosi      = tx_sr_r[WIDTH-1];
  assign rx_data   = rx_data_r;
  assign rx_valid  = rx_valid_r;
  assign busy      = busy_r;

endmodule
